// File: rtl/aes2_ct_drain_if.sv
// Output-side stream of the AES-192 ciphertext drain stage.
// The master side is the AES core plus consumer; the slave side is the drain stage.
interface aes2_ct_drain_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [127:0]     ct_i;
    logic             ct_valid_i;
    logic             clr_i;
    logic [31:0]      word_o;
    logic             word_valid_o;
    logic             word_ready_i;
    logic             word_last_o;
    logic [LW-1:0]    level_o;
    logic             full_o;
    logic             overflow_o;
    logic [CNT_W-1:0] drop_cnt_o;

    modport master (
        output ct_i, ct_valid_i, clr_i, word_ready_i,
        input  word_o, word_valid_o, word_last_o, level_o, full_o, overflow_o, drop_cnt_o
    );

    modport slave (
        input  ct_i, ct_valid_i, clr_i, word_ready_i,
        output word_o, word_valid_o, word_last_o, level_o, full_o, overflow_o, drop_cnt_o
    );
endinterface

// File: rtl/aes2_ct_drain.sv
// Captures one 128-bit ciphertext per rising edge of the core's level valid
// into a small FIFO and drains it as 32-bit words over a valid/ready stream.
module aes2_ct_drain #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    aes2_ct_drain_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic             prev_q;
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [1:0]       widx_q, widx_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [127:0]     mem_q [DEPTH];

    logic             rise;
    logic             full;
    logic             not_empty;
    logic             hs;
    logic             pop;
    logic             push;
    logic             drop;
    logic [127:0]     head;
    logic [31:0]      word;

    assign rise      = bus.ct_valid_i & ~prev_q;
    assign full      = (cnt_q == LW'(DEPTH));
    assign not_empty = (cnt_q != '0);
    assign hs        = not_empty & bus.word_ready_i;
    assign pop       = hs & (widx_q == 2'd3);
    // A full FIFO drops the capture even when a pop frees a slot this cycle.
    assign push      = rise & ~full & ~bus.clr_i;
    assign drop      = rise & full & ~bus.clr_i;
    assign head      = mem_q[rp_q];

    // Select the current 32-bit word of the head entry; zero while empty.
    always_comb begin
        word = '0;
        case (widx_q)
            2'd0: word = head[31:0];
            2'd1: word = head[63:32];
            2'd2: word = head[95:64];
            2'd3: word = head[127:96];
            default: word = '0;
        endcase
        if (!not_empty) begin
            word = '0;
        end
    end

    // Next-state for pointers, occupancy, word index and drop tracking; clear wins.
    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        widx_d = widx_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (bus.clr_i) begin
            wp_d   = '0;
            rp_d   = '0;
            cnt_d  = '0;
            widx_d = '0;
            ovf_d  = 1'b0;
            drop_d = '0;
        end else begin
            if (push) begin
                wp_d = wp_q + PW'(1);
            end
            if (hs) begin
                widx_d = widx_q + 2'd1;
            end
            if (pop) begin
                rp_d = rp_q + PW'(1);
            end
            cnt_d = cnt_q + LW'(push) - LW'(pop);
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != {CNT_W{1'b1}}) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers; prev_q resets high so a level already present at release is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b1;
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            widx_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            prev_q <= bus.ct_valid_i;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            widx_q <= widx_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    // Ciphertext storage, written on accepted captures only.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wp_q] <= bus.ct_i;
        end
    end

    assign bus.word_o       = word;
    assign bus.word_valid_o = not_empty;
    assign bus.word_last_o  = not_empty & (widx_q == 2'd3);
    assign bus.level_o      = cnt_q;
    assign bus.full_o       = full;
    assign bus.overflow_o   = ovf_q;
    assign bus.drop_cnt_o   = drop_q;
endmodule

// File: tb/tb_aes2_ct_drain.sv
// Directed bench for the ciphertext drain stage (DEPTH=4, CNT_W=8).
// Inputs are driven and outputs checked on the falling edge.
module tb_aes2_ct_drain;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    aes2_ct_drain_if #(.DEPTH(4), .CNT_W(8)) bus ();

    aes2_ct_drain #(.DEPTH(4), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    logic [127:0] blk [6];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wsel(input logic [127:0] b, input int i);
        logic [127:0] t;
        t = b;
        return t[i*32 +: 32];
    endfunction

    // One capture: level high for one edge, then low for one edge.
    task automatic cap(input logic [127:0] b);
        bus.ct_i       = b;
        bus.ct_valid_i = 1'b1;
        @(negedge clk);
        bus.ct_valid_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        blk[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        blk[1] = 128'h10101010_20202020_30303030_40404040;
        blk[2] = 128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4;
        blk[3] = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        blk[4] = 128'h55555555_66666666_77777777_88888888;
        blk[5] = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;

        bus.ct_i         = '0;
        bus.ct_valid_i   = 1'b0;
        bus.clr_i        = 1'b0;
        bus.word_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_valid", bus.word_valid_o, 1'b0);
        chk("rst_last",  bus.word_last_o, 1'b0);
        chk("rst_level", bus.level_o, 3'd0);
        chk("rst_full",  bus.full_o, 1'b0);
        chk("rst_ovf",   bus.overflow_o, 1'b0);
        chk("rst_drop",  bus.drop_cnt_o, 8'd0);
        chk("rst_word",  bus.word_o, 32'h0);

        // 1: single capture, level held 10 cycles, ready high
        bus.ct_i         = blk[0];
        bus.ct_valid_i   = 1'b1;
        bus.word_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("t1_valid", bus.word_valid_o, 1'b1);
                chk("t1_word",  bus.word_o, wsel(blk[0], i));
                chk("t1_last",  bus.word_last_o, (i == 3));
                chk("t1_level", bus.level_o, 3'd1);
            end else begin
                chk("t1_valid_after", bus.word_valid_o, 1'b0);
                chk("t1_level_after", bus.level_o, 3'd0);
            end
        end
        bus.ct_valid_i = 1'b0;
        @(negedge clk);

        // 2: backpressure, ready toggling
        bus.word_ready_i = 1'b0;
        bus.ct_i         = blk[0];
        bus.ct_valid_i   = 1'b1;
        @(negedge clk);
        bus.ct_valid_i   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t2_valid", bus.word_valid_o, 1'b1);
            chk("t2_word",  bus.word_o, wsel(blk[0], k / 2));
            chk("t2_last",  bus.word_last_o, (k / 2 == 3));
            bus.word_ready_i = (k % 2 == 1);
            @(negedge clk);
        end
        chk("t2_drained", bus.word_valid_o, 1'b0);
        chk("t2_level",   bus.level_o, 3'd0);

        // 3: overflow with six captures and ready low
        bus.word_ready_i = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cap(blk[c]);
            if (c == 2) chk("t3_notfull3", bus.full_o, 1'b0);
            if (c == 3) begin
                chk("t3_full4",  bus.full_o, 1'b1);
                chk("t3_ovf4",   bus.overflow_o, 1'b0);
            end
        end
        chk("t3_level", bus.level_o, 3'd4);
        chk("t3_ovf",   bus.overflow_o, 1'b1);
        chk("t3_drop",  bus.drop_cnt_o, 8'd2);
        bus.word_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_word", bus.word_o, wsel(blk[i / 4], i % 4));
            chk("t3_last", bus.word_last_o, (i % 4 == 3));
            @(negedge clk);
        end
        chk("t3_empty", bus.word_valid_o, 1'b0);
        chk("t3_ovf_sticky", bus.overflow_o, 1'b1);

        // 4: rise on full in the same cycle as the word-3 pop
        bus.word_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) cap(blk[c]);
        chk("t4_full", bus.full_o, 1'b1);
        bus.word_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_word", bus.word_o, wsel(blk[0], i));
            @(negedge clk);
        end
        chk("t4_last", bus.word_last_o, 1'b1);
        bus.ct_i       = blk[4];
        bus.ct_valid_i = 1'b1;
        @(negedge clk);
        bus.ct_valid_i   = 1'b0;
        bus.word_ready_i = 1'b0;
        chk("t4_level", bus.level_o, 3'd3);
        chk("t4_drop",  bus.drop_cnt_o, 8'd3);
        chk("t4_full_after", bus.full_o, 1'b0);
        chk("t4_head",  bus.word_o, wsel(blk[1], 0));

        // 5a: clear at widx=2 with 3 entries, with a rise in the same cycle
        bus.word_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.word_ready_i = 1'b0;
        chk("t5_pre_word",  bus.word_o, wsel(blk[1], 2));
        chk("t5_pre_level", bus.level_o, 3'd3);
        bus.clr_i      = 1'b1;
        bus.ct_i       = blk[5];
        bus.ct_valid_i = 1'b1;
        @(negedge clk);
        bus.clr_i = 1'b0;
        chk("t5_level", bus.level_o, 3'd0);
        chk("t5_valid", bus.word_valid_o, 1'b0);
        chk("t5_word",  bus.word_o, 32'h0);
        chk("t5_ovf",   bus.overflow_o, 1'b0);
        chk("t5_drop",  bus.drop_cnt_o, 8'd0);
        @(negedge clk);
        chk("t5_no_late_capture", bus.level_o, 3'd0);
        bus.ct_valid_i = 1'b0;
        @(negedge clk);

        // 5b: reset with an entry held and ct_valid high at release
        cap(blk[2]);
        chk("t5_held", bus.level_o, 3'd1);
        bus.ct_valid_i = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_level", bus.level_o, 3'd0);
        @(negedge clk);
        chk("t5_rst_nocap", bus.word_valid_o, 1'b0);
        bus.ct_valid_i = 1'b0;
        @(negedge clk);
        bus.ct_i       = blk[3];
        bus.ct_valid_i = 1'b1;
        @(negedge clk);
        chk("t5_recap_level", bus.level_o, 3'd1);
        chk("t5_recap_word",  bus.word_o, wsel(blk[3], 0));
        bus.ct_valid_i = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes2_ct_drain.md
# aes2_ct_drain

Output-side stage for the AES-192 peripheral. It watches the core's level-style `out_valid`/`out` pair and captures one 128-bit ciphertext per rising edge of `out_valid` into a small FIFO. Software or a DMA agent then drains the captured results as 32-bit words over a valid/ready stream. The stage sits between `aes_192_sed` and the register/bus read path, so results are no longer lost when a new `start` is issued before the previous ciphertext was read.

## Interface

Parameters:
- `DEPTH`, default 4: number of 128-bit FIFO entries. Must be a power of two, 2..16.
- `CNT_W`, default 8: width of the saturating drop counter.

Ports (one clock; reset is synchronous and active-high):
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: synchronous active-high reset.
- `ct_i`, in, 128: ciphertext from the AES core. Only meaningful while `ct_valid_i` is high.
- `ct_valid_i`, in, 1: level valid from the AES core. Stays high until the next start.
- `clr_i`, in, 1: synchronous flush of the FIFO, serializer and error state.
- `word_o`, out, 32: current output word.
- `word_valid_o`, out, 1: `word_o` is valid.
- `word_ready_i`, in, 1: consumer accepts `word_o`.
- `word_last_o`, out, 1: `word_o` is word 3, the last word of its block.
- `level_o`, out, $clog2(DEPTH)+1: number of occupied entries.
- `full_o`, out, 1: level equals DEPTH.
- `overflow_o`, out, 1: sticky; set when a capture was dropped.
- `drop_cnt_o`, out, CNT_W: saturating count of dropped captures.

## Operation

Edge detection:
- `prev_q` holds the registered copy of `ct_valid_i`.
- `rise = ct_valid_i & ~prev_q`. `prev_q` updates every cycle, including cycles where `clr_i` is high.

FIFO:
- Circular buffer of DEPTH x 128 with write pointer `wp`, read pointer `rp` and a registered `count`.
- Pointers wrap modulo DEPTH.

Push:
- On `rise` with `clr_i` low and `count < DEPTH` (count taken at the start of the cycle), write `ct_i` at `wp`.
- On `rise` with `count == DEPTH`, the block is dropped, even if a pop completes in the same cycle. This sets `overflow_o` and increments `drop_cnt_o`, which saturates at 2^CNT_W-1.

Serializer:
- A 2-bit word index `widx` selects the output word from the head entry: 0 gives [31:0], 1 gives [63:32], 2 gives [95:64], 3 gives [127:96].
- `word_valid_o = (count != 0)`.
- `word_last_o = word_valid_o & (widx == 3)`.
- A handshake (`word_valid_o & word_ready_i`) increments `widx`.
- A handshake at `widx == 3` pops the entry: `rp` increments, `widx` returns to 0, and `count` decrements.

Simultaneous push and pop (not full): `count` is unchanged and both pointers advance.

`clr_i`:
- Sets `count`, `wp`, `rp` and `widx` to 0, clears `overflow_o` and `drop_cnt_o`.
- Has priority over a push or pop in the same cycle. A `rise` in that cycle is discarded without counting as a drop.

`word_o` and `word_last_o` must be held stable while `word_valid_o` is high and `word_ready_i` is low. The FIFO storage needs no reset.

## Timing

Reset values:
- `word_valid_o` = 0, `word_last_o` = 0, `level_o` = 0, `full_o` = 0, `overflow_o` = 0, `drop_cnt_o` = 0.
- `word_o` = 0 while empty; it is muxed from storage, gated by `count != 0`.
- Internally, `wp`, `rp`, `widx` and `count` reset to 0, and `prev_q` resets to 1. A `ct_valid_i` that is already high when reset releases is therefore not captured; only a later 0-to-1 transition is.

Latency and throughput:
- Capture to output: a `rise` sampled at edge N makes `word_valid_o` high after edge N, with word 0 of that block if the FIFO was empty.
- Throughput is one word per cycle with `word_ready_i` held high. Four handshakes drain one block, so back-to-back blocks stream without bubbles.

Boundary conditions:
- `level_o`, `full_o`, `overflow_o` and `drop_cnt_o` are registered and reflect the state after the last edge.
- Reset asserted mid-drain discards all entries and partial word progress.
- A `rise` can occur at most once per two cycles, because the input must fall first. No same-cycle double capture is possible.

## Test plan

1. Single capture:
   - Stimulus: `ct_i=128'h00112233_44556677_8899AABB_CCDDEEFF`, pulse `ct_valid_i` high for 10 cycles, `word_ready_i=1`.
   - Required response: words CCDDEEFF, 8899AABB, 44556677, 00112233 on four consecutive cycles, `word_last_o` only on the fourth, one capture despite the 10-cycle level, `level_o` 1 then 0.
2. Backpressure:
   - Stimulus: same block, `word_ready_i` toggling 0/1 every cycle.
   - Required response: each word held stable while ready is low, 8 cycles to drain, no duplicated or skipped word.
3. Overflow (DEPTH=4):
   - Stimulus: 6 captures with `word_ready_i=0`.
   - Required response: `full_o=1` after the 4th, `overflow_o=1`, `drop_cnt_o=2`; draining then yields exactly captures 1-4 in order.
4. Push on full with simultaneous pop:
   - Stimulus: FIFO full, a `rise` in the same cycle as the word-3 handshake.
   - Required response: block dropped, `drop_cnt_o` +1, `level_o`=3.
5. Flush and reset:
   - Stimulus: `clr_i` mid-block at `widx=2` with 3 entries.
   - Required response: `level_o=0`, `word_valid_o=0` next cycle, counters cleared.
   - Stimulus: `rst_i` released while `ct_valid_i=1`.
   - Required response: no capture until `ct_valid_i` falls and rises again.
